// File: rtl/rom_dl_writer.sv
// Packs a byte-wide ROM download stream into 16-bit big-endian words, queues
// them with their word address, and replays them to an SDRAM write port using
// a level request / one-cycle acknowledge handshake.
//
// Ports:
//   clk_sys, reset_n            clock and synchronous active-low reset
//   ioctl_downl/wr/addr/dout    byte download stream
//   wr_req/wr_addr/wr_data      SDRAM write request with word address and data
//   wr_ack                      one-cycle acceptance of the current request
//   rom_loaded                  level: every downloaded byte has been written
//   done                        one-cycle pulse when rom_loaded rises
//   overflow                    sticky: a word was dropped on a full queue
module rom_dl_writer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AW         = 24
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_downl,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          wr_req,
  output logic [AW-2:0] wr_addr,
  output logic [15:0]   wr_data,
  input  logic          wr_ack,
  output logic          rom_loaded,
  output logic          done,
  output logic          overflow
);

  localparam int unsigned WAW = AW - 1;
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

  state_t         r_state, w_next;
  logic           r_downl_d;
  logic           r_hold_valid;
  logic [7:0]     r_hold_hi;
  logic [WAW-1:0] r_hold_addr;
  logic [CW-1:0]  r_wp, r_rp;
  logic           r_wr_req;
  logic [WAW-1:0] r_wr_addr;
  logic [15:0]    r_wr_data;
  logic           r_rom_loaded, r_done, r_overflow;

  logic [WAW-1:0] r_mem_addr [FIFO_DEPTH];
  logic [15:0]    r_mem_data [FIFO_DEPTH];

  logic [WAW-1:0] w_waddr;
  logic           w_rise, w_pop, w_drop;
  logic [CW-1:0]  w_count, w_free, w_wp1;
  logic [1:0]     w_req_n, w_n_acc;
  logic [WAW-1:0] w_a_addr, w_b_addr;
  logic [15:0]    w_a_data, w_b_data;
  logic           w_clear, w_hold_load, w_hold_clr, w_finish;

  // Upper address bits beyond the write port width are discarded by design.
  if (AW < 25) begin : g_addr_hi
    logic w_unused_hi;
    assign w_unused_hi = ^ioctl_addr[24:AW];
  end

  assign w_waddr = ioctl_addr[AW-1:1];
  assign w_rise  = ioctl_downl & ~r_downl_d;
  assign w_pop   = r_wr_req & wr_ack;
  assign w_count = r_wp - r_rp;
  assign w_free  = CW'(FIFO_DEPTH) - w_count;
  assign w_wp1   = r_wp + CW'(1);

  // Entries are accepted in order; whatever does not fit is dropped.
  assign w_drop  = w_free < CW'(w_req_n);
  assign w_n_acc = w_drop ? {1'b0, (w_free != '0)} : w_req_n;

  // State register.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next state, byte packing decisions and queue push requests.
  always_comb begin
    w_next      = r_state;
    w_clear     = 1'b0;
    w_req_n     = 2'd0;
    w_a_addr    = '0;
    w_a_data    = '0;
    w_b_addr    = '0;
    w_b_data    = '0;
    w_hold_load = 1'b0;
    w_hold_clr  = 1'b0;
    w_finish    = 1'b0;
    if (w_rise && (r_state != S_LOAD)) begin
      w_next  = S_LOAD;
      w_clear = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: w_next = S_IDLE;
        S_LOAD: begin
          if (!ioctl_downl) begin
            w_next = S_FLUSH;
          end else if (ioctl_wr) begin
            if (!ioctl_addr[0]) begin
              w_hold_load = 1'b1;
              if (r_hold_valid) begin
                w_req_n  = 2'd1;
                w_a_addr = r_hold_addr;
                w_a_data = {r_hold_hi, 8'h00};
              end
            end else begin
              w_hold_clr = 1'b1;
              if (r_hold_valid && (r_hold_addr == w_waddr)) begin
                w_req_n  = 2'd1;
                w_a_addr = w_waddr;
                w_a_data = {r_hold_hi, ioctl_dout};
              end else if (r_hold_valid) begin
                w_req_n  = 2'd2;
                w_a_addr = r_hold_addr;
                w_a_data = {r_hold_hi, 8'h00};
                w_b_addr = w_waddr;
                w_b_data = {8'h00, ioctl_dout};
              end else begin
                w_req_n  = 2'd1;
                w_a_addr = w_waddr;
                w_a_data = {8'h00, ioctl_dout};
              end
            end
          end
        end
        // A trailing even byte waits here until the queue has room for it.
        S_FLUSH: begin
          if (!r_hold_valid) begin
            w_next = S_DRAIN;
          end else if (w_free != '0) begin
            w_req_n    = 2'd1;
            w_a_addr   = r_hold_addr;
            w_a_data   = {r_hold_hi, 8'h00};
            w_hold_clr = 1'b1;
            w_next     = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((w_count == '0) && !r_wr_req) begin
            w_next   = S_IDLE;
            w_finish = 1'b1;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Queue storage; the second port is used only when two words arrive at once.
  always_ff @(posedge clk_sys) begin
    if (w_n_acc != 2'd0) begin
      r_mem_addr[r_wp[PW-1:0]] <= w_a_addr;
      r_mem_data[r_wp[PW-1:0]] <= w_a_data;
    end
    if (w_n_acc == 2'd2) begin
      r_mem_addr[w_wp1[PW-1:0]] <= w_b_addr;
      r_mem_data[w_wp1[PW-1:0]] <= w_b_data;
    end
  end

  // Control registers, hold register, queue pointers and write port.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_downl_d    <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_hi    <= '0;
      r_hold_addr  <= '0;
      r_wp         <= '0;
      r_rp         <= '0;
      r_wr_req     <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_rom_loaded <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_downl_d <= ioctl_downl;
      r_done    <= w_finish;
      if (w_finish) r_rom_loaded <= 1'b1;
      if (w_clear) begin
        r_rom_loaded <= 1'b0;
        r_overflow   <= 1'b0;
        r_hold_valid <= 1'b0;
        r_wp         <= '0;
        r_rp         <= '0;
        r_wr_req     <= 1'b0;
      end else begin
        if (w_drop) r_overflow <= 1'b1;
        if (w_hold_load) begin
          r_hold_valid <= 1'b1;
          r_hold_hi    <= ioctl_dout;
          r_hold_addr  <= w_waddr;
        end else if (w_hold_clr) begin
          r_hold_valid <= 1'b0;
        end
        r_wp <= r_wp + CW'(w_n_acc);
        // After an ack the request stays low for one cycle before the next head.
        if (w_pop) begin
          r_rp     <= r_rp + CW'(1);
          r_wr_req <= 1'b0;
        end else if (!r_wr_req) begin
          if (w_count != '0) begin
            r_wr_req  <= 1'b1;
            r_wr_addr <= r_mem_addr[r_rp[PW-1:0]];
            r_wr_data <= r_mem_data[r_rp[PW-1:0]];
          end else if (w_n_acc != 2'd0) begin
            // Empty queue: present the word being pushed without waiting a cycle.
            r_wr_req  <= 1'b1;
            r_wr_addr <= w_a_addr;
            r_wr_data <= w_a_data;
          end
        end
      end
    end
  end

  assign wr_req     = r_wr_req;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign rom_loaded = r_rom_loaded;
  assign done       = r_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_rom_dl_writer.sv
// Scoreboard bench for rom_dl_writer: a byte-level packing model predicts the
// word writes, and a monitor acknowledges and checks every request.
module tb_rom_dl_writer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 24;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          ioctl_downl, ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          wr_req;
  logic [AW-2:0] wr_addr;
  logic [15:0]   wr_data;
  logic          wr_ack;
  logic          rom_loaded, done, overflow;
  logic          ack_mon   = 1'b0;
  logic          ack_force = 1'b0;

  assign wr_ack = ack_mon | ack_force;

  always #5 clk_sys = ~clk_sys;

  rom_dl_writer #(.FIFO_DEPTH(DEPTH), .AW(AW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_downl(ioctl_downl),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rom_loaded(rom_loaded), .done(done), .overflow(overflow)
  );

  typedef struct { int unsigned a; int unsigned d; } wr_t;
  wr_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit          m_hv;
  int unsigned m_hh, m_ha;
  int          pushed, popped;
  bit          ack_en    = 1'b0;
  int          ack_delay = 0;
  int          done_cnt  = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_push(input int unsigned a, input int unsigned d);
    if (pushed - popped < int'(DEPTH)) begin
      exp_q.push_back('{a: a, d: d});
      pushed++;
    end
  endtask

  // Big-endian pairing of bytes into words, straight from the packing rules.
  task automatic m_byte(input int unsigned addr, input int unsigned d);
    int unsigned wa;
    wa = (addr >> 1) % (32'd1 << (AW - 1));
    if (addr % 2 == 0) begin
      if (m_hv) m_push(m_ha, m_hh * 256);
      m_hv = 1'b1; m_hh = d; m_ha = wa;
    end else begin
      if (m_hv && m_ha == wa) m_push(wa, m_hh * 256 + d);
      else begin
        if (m_hv) m_push(m_ha, m_hh * 256);
        m_push(wa, d);
      end
      m_hv = 1'b0;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_hv = 1'b0; pushed = 0; popped = 0;
  endtask

  task automatic start_dl();
    ioctl_downl = 1'b1;
    model_clear();
    done_cnt = 0;
    cyc(2);
  endtask

  task automatic send(input int unsigned a, input int unsigned d, input int gap);
    ioctl_addr = 25'(a);
    ioctl_dout = 8'(d);
    ioctl_wr   = 1'b1;
    m_byte(a, d);
    cyc(1);
    ioctl_wr = 1'b0;
    cyc(gap);
  endtask

  task automatic end_dl();
    ioctl_downl = 1'b0;
    if (m_hv) begin
      exp_q.push_back('{a: m_ha, d: m_hh * 256});
      pushed++;
      m_hv = 1'b0;
    end
    cyc(1);
  endtask

  task automatic wait_loaded(input int unsigned exp_ovf);
    int n;
    n = 0;
    while (!rom_loaded && n < 500) begin cyc(1); n++; end
    check("rom_loaded", 32'(rom_loaded), 1);
    cyc(2);
    check("done_pulses", 32'(done_cnt), 1);
    check("overflow", 32'(overflow), exp_ovf);
    check("writes_left", 32'(exp_q.size()), 0);
  endtask

  task automatic check_reset_outs();
    check("rst_wr_req", 32'(wr_req), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_rom_loaded", 32'(rom_loaded), 0);
    check("rst_done", 32'(done), 0);
    check("rst_overflow", 32'(overflow), 0);
  endtask

  // Monitor: check each new request against the scoreboard, hold-stability
  // while pending, acknowledge after a delay, and the low cycle after an ack.
  bit          prev_req = 1'b0;
  bit          acking   = 1'b0;
  int          cnt      = 0;
  int unsigned h_a, h_d;
  always @(negedge clk_sys) begin
    wr_t e;
    if (acking) begin
      ack_mon = 1'b0;
      acking  = 1'b0;
      check("req_gap_after_ack", 32'(wr_req), 0);
    end else if (wr_req) begin
      if (!prev_req) begin
        h_a = 32'(wr_addr);
        h_d = 32'(wr_data);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), e.a);
          check("wr_data", 32'(wr_data), e.d);
        end
        cnt = (ack_delay < 0) ? int'($urandom_range(0, 2)) : ack_delay;
      end else begin
        check("stable_addr", 32'(wr_addr), h_a);
        check("stable_data", 32'(wr_data), h_d);
      end
      if (ack_en) begin
        if (cnt == 0) begin ack_mon = 1'b1; acking = 1'b1; popped++; end
        else cnt--;
      end
    end
    prev_req = wr_req;
    if (done) done_cnt++;
  end

  initial begin
    int unsigned a;
    reset_n = 1'b0; ioctl_downl = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    cyc(2);
    check_reset_outs();
    reset_n = 1'b1;
    cyc(2);

    // Strobes with no download active are ignored.
    ioctl_addr = 25'h1; ioctl_dout = 8'h99; ioctl_wr = 1'b1;
    cyc(1);
    ioctl_wr = 1'b0;
    cyc(5);
    check("idle_no_req", 32'(wr_req), 0);

    // Four bytes, ack two cycles after each request.
    ack_en = 1'b1; ack_delay = 2;
    start_dl();
    send(0, 8'h12, 1); send(1, 8'h34, 1); send(2, 8'h56, 1); send(3, 8'h78, 1);
    end_dl();
    wait_loaded(0);

    // Odd length: trailing byte flushed as a half word.
    start_dl();
    send(16, 8'hAA, 2); send(17, 8'hBB, 2); send(18, 8'hCC, 2);
    end_dl();
    wait_loaded(0);

    // Lone odd byte; request must appear the cycle after the strobe.
    start_dl();
    ioctl_addr = 25'd7; ioctl_dout = 8'h5A; ioctl_wr = 1'b1;
    m_byte(7, 8'h5A);
    cyc(1);
    ioctl_wr = 1'b0;
    check("latency_wr_req", 32'(wr_req), 1);
    cyc(3);
    end_dl();
    wait_loaded(0);

    // Stalled write port: only DEPTH words fit, the rest are dropped.
    ack_en = 1'b0;
    start_dl();
    for (int i = 0; i < 12; i++) send(32'(i), 32'(8'h20 + i), 0);
    cyc(8);
    check("overflow_set", 32'(overflow), 1);
    check("rom_loaded_during", 32'(rom_loaded), 0);
    ack_en = 1'b1; ack_delay = -1;
    end_dl();
    wait_loaded(1);

    // Randomised downloads with address jumps and wrapping upper bits.
    for (int k = 0; k < 6; k++) begin
      int len;
      start_dl();
      a = $urandom & 32'h1FF_FFFF;
      len = int'($urandom_range(1, 10));
      for (int i = 0; i < len; i++) begin
        send(a, $urandom & 32'hFF, int'($urandom_range(9, 14)));
        a = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h1FF_FFFF) : ((a + 1) & 32'h1FF_FFFF);
      end
      end_dl();
      wait_loaded(0);
    end

    // New download while draining: queued words are discarded, no done.
    ack_en = 1'b0;
    start_dl();
    send(0, 8'h01, 1); send(1, 8'h02, 1); send(2, 8'h03, 1); send(3, 8'h04, 1);
    end_dl();
    cyc(3);
    check("drain_rom_loaded", 32'(rom_loaded), 0);
    check("drain_wr_req", 32'(wr_req), 1);
    start_dl();
    cyc(3);
    check("abort_wr_req", 32'(wr_req), 0);
    check("abort_no_done", 32'(done_cnt), 0);
    check("abort_rom_loaded", 32'(rom_loaded), 0);
    ack_en = 1'b1;
    send(32, 8'hC1, 3); send(33, 8'hC2, 3); send(34, 8'hC3, 3); send(35, 8'hC4, 3);
    end_dl();
    wait_loaded(0);

    // Reset mid-request, then a stray ack must not pop anything.
    ack_en = 1'b0;
    start_dl();
    send(64, 8'h11, 1); send(65, 8'h22, 2);
    check("pre_reset_wr_req", 32'(wr_req), 1);
    reset_n = 1'b0; ioctl_downl = 1'b0;
    cyc(1);
    check_reset_outs();
    reset_n = 1'b1;
    model_clear();
    cyc(1);
    ack_force = 1'b1;
    cyc(1);
    ack_force = 1'b0;
    cyc(3);
    check("stray_ack_no_req", 32'(wr_req), 0);
    ack_en = 1'b1; ack_delay = 1;
    start_dl();
    send(80, 8'hE1, 3); send(81, 8'hE2, 3); send(83, 8'hE3, 3);
    end_dl();
    wait_loaded(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rom_dl_writer.md
ROM_DL_WRITER -- requirements
Module: rom_dl_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of pending words, power of two, at least 2.
REQ-002 SHALL have parameter AW, default 24, meaning the byte-address width of the SDRAM write port.
REQ-003 clk_sys  in  1  the single clock; all logic is on its rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 ioctl_downl  in  1  download active, from data_io.
REQ-006 ioctl_wr  in  1  one-cycle byte strobe.
REQ-007 ioctl_addr  in  25  byte address of ioctl_dout.
REQ-008 ioctl_dout  in  8  download byte.
REQ-009 wr_req  out  1  SDRAM write request, a level signal.
REQ-010 wr_addr  out  AW-1  word address, equal to byte address[AW-1:1].
REQ-011 wr_data  out  16  write word.
REQ-012 wr_ack  in  1  one-cycle acceptance from the SDRAM controller.
REQ-013 rom_loaded  out  1  level signal; all downloaded data has been written.
REQ-014 done  out  1  one-cycle pulse when rom_loaded rises.
REQ-015 overflow  out  1  sticky flag; a word was dropped because the FIFO was full.

Function
REQ-016 SHALL pack bytes big-endian: an even-address byte goes to bits [15:8] and an odd-address byte goes to bits [7:0].
REQ-017 SHALL latch an even byte into a holding register (hold_valid=1, hold_addr=ioctl_addr[AW-1:1]) without pushing it.
REQ-018 An odd byte whose word address equals hold_addr while hold_valid=1 SHALL push {hold_hi, byte} in the same cycle and clear hold_valid.
REQ-019 An odd byte that has no matching hold SHALL first push any pending hold as {hold_hi, 8'h00}, then push {8'h00, byte}, using two FIFO slots in one cycle; the FIFO needs at least 2 free slots for this.
REQ-020 An even byte arriving while hold_valid=1 SHALL push the old hold as {hold_hi, 8'h00} and latch the new byte.
REQ-021 Each pushed entry SHALL carry its word address together with its data.
REQ-022 ioctl_wr SHALL be ignored while ioctl_downl=0.
REQ-023 When the FIFO lacks space for a required push, the entry SHALL be dropped and overflow set to 1; all other entries are preserved.
REQ-024 Write port: when the FIFO is non-empty, the head SHALL be presented on wr_addr/wr_data with wr_req=1.
REQ-025 wr_addr and wr_data SHALL be stable while wr_req=1.
REQ-026 On wr_ack the head SHALL pop and wr_req SHALL drop for at least 1 cycle before the next request.
REQ-027 wr_ack while wr_req=0 SHALL be ignored.
REQ-028 A push and a pop in the same cycle SHALL be legal and leave the count unchanged; a push into a full FIFO is still dropped even if a pop occurs that cycle.
REQ-029 FSM states:
- IDLE: rom_loaded holds its value.
- LOAD: entered on the ioctl_downl rising edge; clears rom_loaded, overflow, hold_valid and the FIFO pointers.
- FLUSH: entered on the ioctl_downl falling edge; pushes a pending hold as {hold_hi, 8'h00} when space allows, otherwise waits.
- DRAIN: waits for FIFO empty with wr_req=0.
- then sets rom_loaded=1, pulses done for 1 cycle, and returns to IDLE.
REQ-030 An ioctl_downl rising edge in FLUSH or DRAIN SHALL abort to LOAD, discarding all queued words; done is not pulsed.
REQ-031 Address wrap: bits of ioctl_addr above AW-1 SHALL be discarded with no error.
REQ-032 Latency: a word completed by ioctl_wr in cycle N SHALL assert wr_req in cycle N+1 if the FIFO was empty.

Reset
REQ-033 On reset_n=0 at a clock edge: wr_req=0, wr_addr=0, wr_data=0, rom_loaded=0, done=0, overflow=0, FIFO empty, hold_valid=0, FSM=IDLE.
REQ-034 Reset asserted mid-transfer SHALL abandon an outstanding request, and a wr_ack arriving afterwards SHALL be ignored.
REQ-035 If ioctl_downl=1 when reset releases, the FSM SHALL enter LOAD on the next cycle.

Verification
REQ-036 Bytes 12,34,56,78 at addresses 0-3 with wr_ack 2 cycles after each req -> writes (0,1234) then (1,5678), followed by done pulse, rom_loaded=1, overflow=0.
REQ-037 3-byte download AA,BB,CC at addresses 0x10-0x12 -> writes (8,AABB) then (9,CC00) issued by FLUSH, followed by done.
REQ-038 wr_ack held 0 for 20 cycles while 12 bytes stream in, FIFO_DEPTH=4 -> exactly 4 words queued, overflow=1, later words dropped.
REQ-039 Odd byte 5A at address 7 with no hold -> single write (3,005A).
REQ-040 Second download starting while in DRAIN with 2 words queued -> queue discarded, no done pulse, rom_loaded=0, new data written correctly.
REQ-041 reset_n=0 for 1 cycle while wr_req=1 -> every output reaches its reset value on the next edge, and a following wr_ack causes no pop.
